div_unit: RTL and testbench

- Sequential signed 32-bit divider for the multicycle MIPS datapath. Executes DIV.
- Consumes operands from the A/B register outputs and the `div` start strobe from the control FSM.
- Produces quotient/remainder for the LO/HI input muxes, `done` for the control FSM, and `divzero` for the exception path (vector 255).
- Restoring algorithm, one quotient bit per clock, with sign correction at the end.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 145 ++++++++++++++
 tb/tb_div_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential signed divider.
// Provides the divider FSM state type, the datapath width constants and
// the exception vector used by the CPU top and control when DIV faults.
package div_pkg;

    localparam int WIDTH        = 32;
    localparam int CNT_W        = 5;
    localparam int DIV_EXC_ADDR = 255;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        DONE,
        DZ
    } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports:
//   rem_low     - partial remainder without its MSB (always 0 while running,
//                 since partial remainder < |divisor| <= 2^(WIDTH-1))
//   dvd_bit     - next dividend bit shifted into the remainder
//   divisor_abs - unsigned divisor magnitude
//   rem_next    - partial remainder after this iteration
//   q_bit       - quotient bit produced by this iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-2:0] rem_low,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor_abs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   diff;

    always_comb begin
        rem_shift = {rem_low, dvd_bit};
        // Extra top bit acts as the borrow out of the trial subtraction.
        diff      = {1'b0, rem_shift} - {1'b0, divisor_abs};
        q_bit     = ~diff[WIDTH];
        rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift;
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: sequential signed divider (DIV) for the multicycle datapath.
// Restoring algorithm on operand magnitudes, one quotient bit per clock,
// followed by a sign-correction cycle.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   start     - one-cycle start strobe, only sampled in IDLE
//   dividend  - signed dividend (A register)
//   divisor   - signed divisor (B register)
//   quotient  - signed quotient to LO mux, updated only on the FIX edge
//   remainder - signed remainder to HI mux, updated only on the FIX edge
//   busy      - high in RUN, FIX and DONE
//   done      - one-cycle pulse, results valid
//   divzero   - one-cycle pulse, divisor was zero (results held)
module div_unit #(
    parameter int WIDTH = div_pkg::WIDTH,
    parameter int CNT_W = div_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    import div_pkg::*;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr_abs;
    logic [WIDTH-1:0] partial_rem;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             q_neg;
    logic             r_neg;
    logic [CNT_W-1:0] cnt;
    logic             divisor_zero;

    assign divisor_zero = (divisor == '0);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_low    (partial_rem[WIDTH-2:0]),
        .dvd_bit    (dvd[WIDTH-1]),
        .divisor_abs(dsr_abs),
        .rem_next   (rem_next),
        .q_bit      (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = divisor_zero ? DZ : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            DZ: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd         <= '0;
            dsr_abs     <= '0;
            partial_rem <= '0;
            q_work      <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            divzero     <= 1'b0;
        end else begin
            // Pulses are flopped so they are high exactly in the DONE / DZ cycle.
            done    <= (state == FIX);
            divzero <= (state == IDLE) && start && divisor_zero;
            case (state)
                IDLE: begin
                    if (start && !divisor_zero) begin
                        dvd         <= dividend[WIDTH-1] ? -dividend : dividend;
                        dsr_abs     <= divisor[WIDTH-1] ? -divisor : divisor;
                        q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg       <= dividend[WIDTH-1];
                        partial_rem <= '0;
                        q_work      <= '0;
                        cnt         <= CNT_W'(WIDTH - 1);
                    end
                end
                RUN: begin
                    partial_rem <= rem_next;
                    dvd         <= {dvd[WIDTH-2:0], 1'b0};
                    q_work      <= {q_work[WIDTH-2:0], q_bit};
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    quotient  <= q_neg ? -q_work : q_work;
                    remainder <= r_neg ? -partial_rem : partial_rem;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Expected results come from
// plain signed 64-bit arithmetic (truncating division, remainder takes the
// dividend's sign) plus directed constants.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        divzero;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] held_q = '0;
    logic [31:0] held_r = '0;

    div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .divzero  (divzero)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
    endfunction

    // Drives a one-cycle start; returns at the negedge right after edge 0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Counts negedges until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (quotient !== 32'h0) $display("FAIL rst_q: got %h want 0", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 32'h0) $display("FAIL rst_r: got %h want 0", remainder); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (divzero !== 1'b0) $display("FAIL rst_dz: got %b want 0", divzero); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_directed;
        logic [31:0] ta [5] = '{32'hFFFFFF9C, 32'd100, 32'd0, 32'h80000000, 32'd100};
        logic [31:0] tb [5] = '{32'd7, 32'hFFFFFFF9, 32'd5, 32'hFFFFFFFF, 32'd7};
        logic [31:0] eq [5] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0, 32'h80000000, 32'h0000000E};
        logic [31:0] er [5] = '{32'hFFFFFFFE, 32'd2, 32'h0, 32'h0, 32'd2};
        int n;
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i]);
            total_cnt++; if (busy !== 1'b1) $display("FAIL dir_busy[%0d]: got %b want 1", i, busy); else pass_cnt++;
            total_cnt++; if (divzero !== 1'b0) $display("FAIL dir_nodz[%0d]: got %b want 0", i, divzero); else pass_cnt++;
            wait_done(n);
            total_cnt++; if (n !== 33) $display("FAIL dir_lat[%0d]: got %0d want 33", i, n); else pass_cnt++;
            total_cnt++; if (quotient !== eq[i]) $display("FAIL dir_q[%0d]: got %h want %h", i, quotient, eq[i]); else pass_cnt++;
            total_cnt++; if (remainder !== er[i]) $display("FAIL dir_r[%0d]: got %h want %h", i, remainder, er[i]); else pass_cnt++;
            held_q = eq[i];
            held_r = er[i];
            @(negedge clk);
            total_cnt++; if (done !== 1'b0) $display("FAIL dir_pulse[%0d]: got %b want 0", i, done); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL dir_busy_after[%0d]: got %b want 0", i, busy); else pass_cnt++;
        end
    endtask

    task automatic test_divzero;
        int seen;
        start_op(32'd5, 32'd0);
        total_cnt++; if (divzero !== 1'b1) $display("FAIL dz_pulse: got %b want 1", divzero); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL dz_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL dz_done: got %b want 0", done); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (divzero !== 1'b0) $display("FAIL dz_width: got %b want 0", divzero); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy || divzero) seen++;
            @(negedge clk);
        end
        total_cnt++; if (seen !== 0) $display("FAIL dz_quiet: got %0d active cycles want 0", seen); else pass_cnt++;
        total_cnt++; if (quotient !== held_q) $display("FAIL dz_hold_q: got %h want %h", quotient, held_q); else pass_cnt++;
        total_cnt++; if (remainder !== held_r) $display("FAIL dz_hold_r: got %h want %h", remainder, held_r); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int n;
        start_op(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(n);
        total_cnt++; if (n !== 23) $display("FAIL ign_lat: got %0d want 23", n); else pass_cnt++;
        total_cnt++; if (quotient !== 32'd14) $display("FAIL ign_q: got %h want 0000000e", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 32'd2) $display("FAIL ign_r: got %h want 00000002", remainder); else pass_cnt++;
        held_q = 32'd14;
        held_r = 32'd2;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int n;
        int seen;
        start_op(32'd100, 32'd7);
        repeat (15) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total_cnt++; if (quotient !== 32'h0) $display("FAIL abort_q: got %h want 0", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 32'h0) $display("FAIL abort_r: got %h want 0", remainder); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
        held_q = '0;
        held_r = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || divzero || busy) seen++;
        end
        total_cnt++; if (seen !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", seen); else pass_cnt++;
        start_op(32'd9, 32'd3);
        wait_done(n);
        total_cnt++; if (n !== 33) $display("FAIL abort_lat: got %0d want 33", n); else pass_cnt++;
        total_cnt++; if (quotient !== 32'd3) $display("FAIL abort_q2: got %h want 00000003", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 32'd0) $display("FAIL abort_r2: got %h want 0", remainder); else pass_cnt++;
        held_q = 32'd3;
        held_r = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        logic [31:0] c;
        logic [31:0] cd;
        logic [31:0] eq;
        logic [31:0] er;
        int n;
        a  = $urandom;
        c  = $urandom;
        cd = $urandom_range(1, 1000);
        start_op(a, 32'd3);
        wait_done(n);
        total_cnt++; if (n !== 33) $display("FAIL b2b_lat1: got %0d want 33", n); else pass_cnt++;
        // Start held across the DONE cycle (ignored) and the IDLE cycle (accepted).
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy); else pass_cnt++;
        dividend = c;
        divisor  = cd;
        @(negedge clk);
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else pass_cnt++;
        model(c, cd, eq, er);
        wait_done(n);
        total_cnt++; if (n !== 33) $display("FAIL b2b_lat2: got %0d want 33", n); else pass_cnt++;
        total_cnt++; if (quotient !== eq) $display("FAIL b2b_q: got %h want %h", quotient, eq); else pass_cnt++;
        total_cnt++; if (remainder !== er) $display("FAIL b2b_r: got %h want %h", remainder, er); else pass_cnt++;
        held_q = eq;
        held_r = er;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        int n;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'($signed($urandom_range(0, 400)) - 200);
                2: a = 32'h80000000;
                default: a = $urandom_range(0, 65535);
            endcase
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($signed($urandom_range(0, 40)) - 20);
                2: b = 32'h0;
                3: b = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h80000000;
                default: b = $urandom_range(1, 300);
            endcase
            start_op(a, b);
            if (b == 32'h0) begin
                total_cnt++; if (divzero !== 1'b1) $display("FAIL rnd_dz[%0d]: got %b want 1", i, divzero); else pass_cnt++;
                @(negedge clk);
                total_cnt++; if (quotient !== held_q) $display("FAIL rnd_dz_q[%0d]: got %h want %h", i, quotient, held_q); else pass_cnt++;
                total_cnt++; if (remainder !== held_r) $display("FAIL rnd_dz_r[%0d]: got %h want %h", i, remainder, held_r); else pass_cnt++;
            end else begin
                model(a, b, eq, er);
                wait_done(n);
                total_cnt++; if (n !== 33) $display("FAIL rnd_lat[%0d]: got %0d want 33", i, n); else pass_cnt++;
                total_cnt++; if (quotient !== eq) $display("FAIL rnd_q[%0d] %h/%h: got %h want %h", i, a, b, quotient, eq); else pass_cnt++;
                total_cnt++; if (remainder !== er) $display("FAIL rnd_r[%0d] %h/%h: got %h want %h", i, a, b, remainder, er); else pass_cnt++;
                held_q = eq;
                held_r = er;
                @(negedge clk);
                total_cnt++; if (done !== 1'b0) $display("FAIL rnd_pulse[%0d]: got %b want 0", i, done); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_divzero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
